// File: rtl/shift_pkg.sv
// Shared constants and helpers for the pipelined barrel shifter.
package shift_pkg;

  localparam logic [1:0] MODE_SLL = 2'd0;
  localparam logic [1:0] MODE_SRA = 2'd1;
  localparam logic [1:0] MODE_ROR = 2'd2;
  localparam logic [1:0] MODE_SRL = 2'd3;

  // Ceiling log2, used to size the shift-amount field from the data width.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One combinational log stage: shifts or rotates right/left by a fixed DIST when enabled.
module shift_stage
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIST  = 1
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic             i_sign,
  output logic [WIDTH-1:0] o_data
);

  // Select fill per mode; i_sign is the operand's original MSB, not this stage's input MSB.
  always_comb begin
    o_data = i_data;
    if (i_en) begin
      case (i_mode)
        MODE_SLL: o_data = {i_data[WIDTH-DIST-1:0], {DIST{1'b0}}};
        MODE_SRA: o_data = {{DIST{i_sign}}, i_data[WIDTH-1:DIST]};
        MODE_ROR: o_data = {i_data[DIST-1:0], i_data[WIDTH-1:DIST]};
        default:  o_data = {{DIST{1'b0}}, i_data[WIDTH-1:DIST]};
      endcase
    end
  end

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter with valid/ready handshake and a single global stall.
module shift_unit_pipe
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned REG_EVERY = 2,
  parameter int unsigned TAG_W     = 4,
  localparam int unsigned SHW      = clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned LAT = (SHW + REG_EVERY - 1) / REG_EVERY;

  // Register slot g sits after group g of REG_EVERY log stages.
  logic             r_valid [LAT];
  logic [WIDTH-1:0] r_data  [LAT];
  logic [SHW-1:0]   r_shamt [LAT];
  logic [1:0]       r_mode  [LAT];
  logic             r_sign  [LAT];
  logic [TAG_W-1:0] r_tag   [LAT];
  logic             r_zero;

  // Sources feeding each group: the input port for group 0, the previous slot otherwise.
  logic             w_g_valid [LAT];
  logic [WIDTH-1:0] w_g_data  [LAT];
  logic [SHW-1:0]   w_g_shamt [LAT];
  logic [1:0]       w_g_mode  [LAT];
  logic             w_g_sign  [LAT];
  logic [TAG_W-1:0] w_g_tag   [LAT];

  logic [WIDTH-1:0] w_st_in   [SHW];
  logic [WIDTH-1:0] w_st_out  [SHW];
  logic [WIDTH-1:0] w_grp_out [LAT];
  logic             w_stall;
  logic             w_unused;

  assign w_stall   = r_valid[LAT-1] & ~out_ready;
  assign in_ready  = ~w_stall;

  assign out_valid = r_valid[LAT-1];
  assign out_data  = r_data[LAT-1];
  assign out_tag   = r_tag[LAT-1];
  assign out_zero  = r_zero;

  assign w_g_valid[0] = in_valid;
  assign w_g_data[0]  = in_data;
  assign w_g_shamt[0] = in_shamt;
  assign w_g_mode[0]  = in_mode;
  assign w_g_sign[0]  = in_data[WIDTH-1];
  assign w_g_tag[0]   = in_tag;

  for (genvar g = 1; g < LAT; g++) begin : g_src
    assign w_g_valid[g] = r_valid[g-1];
    assign w_g_data[g]  = r_data[g-1];
    assign w_g_shamt[g] = r_shamt[g-1];
    assign w_g_mode[g]  = r_mode[g-1];
    assign w_g_sign[g]  = r_sign[g-1];
    assign w_g_tag[g]   = r_tag[g-1];
  end

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int unsigned G = k / REG_EVERY;
    if (k % REG_EVERY == 0) begin : g_head
      assign w_st_in[k] = w_g_data[G];
    end else begin : g_body
      assign w_st_in[k] = w_st_out[k-1];
    end

    shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << k)
    ) u_stage (
      .i_data (w_st_in[k]),
      .i_en   (w_g_shamt[G][k]),
      .i_mode (w_g_mode[G]),
      .i_sign (w_g_sign[G]),
      .o_data (w_st_out[k])
    );
  end

  for (genvar g = 0; g < LAT; g++) begin : g_grp
    localparam int unsigned LAST =
        ((g + 1) * REG_EVERY < SHW) ? (g + 1) * REG_EVERY - 1 : SHW - 1;
    assign w_grp_out[g] = w_st_out[LAST];
  end

  // Pipeline registers: all slots advance together unless the output is blocked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned g = 0; g < LAT; g++) begin
        r_valid[g] <= 1'b0;
        r_data[g]  <= '0;
        r_shamt[g] <= '0;
        r_mode[g]  <= '0;
        r_sign[g]  <= 1'b0;
        r_tag[g]   <= '0;
      end
      r_zero <= 1'b0;
    end else if (!w_stall) begin
      for (int unsigned g = 0; g < LAT; g++) begin
        r_valid[g] <= w_g_valid[g];
        r_data[g]  <= w_grp_out[g];
        r_shamt[g] <= w_g_shamt[g];
        r_mode[g]  <= w_g_mode[g];
        r_sign[g]  <= w_g_sign[g];
        r_tag[g]   <= w_g_tag[g];
      end
      r_zero <= (w_grp_out[LAT-1] == '0);
    end
  end

  // Shamt bits already consumed and the last slot's control fields have no reader.
  always_comb begin
    w_unused = 1'b0;
    for (int unsigned g = 0; g < LAT; g++) begin
      w_unused = w_unused ^ (^{r_shamt[g], r_mode[g], r_sign[g], w_g_shamt[g]});
    end
  end

endmodule
